// File: rtl/instr_fetch_axi_master_if.sv
// AXI4 read-only channel bundle (AR + R) between the fetch master and the
// instruction-memory slave.
interface instr_fetch_axi_master_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] araddr;
    logic                  arvalid;
    logic                  arready;
    logic [2:0]            arprot;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output araddr, arvalid, arprot, rready,
        input  arready, rdata, rresp, rvalid
    );

    modport slave (
        input  araddr, arvalid, arprot, rready,
        output arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/instr_fetch_axi_master.sv
// Instruction-fetch req/gnt/rvalid to AXI4 single-beat read bridge.
// One outstanding transaction; back-to-back requests go straight from the
// R handshake to a new AR without passing through IDLE.
module instr_fetch_axi_master #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  instr_req_i,
    input  logic [ADDR_WIDTH-1:0] instr_addr_i,
    output logic                  instr_gnt_o,
    output logic                  instr_rvalid_o,
    output logic [DATA_WIDTH-1:0] instr_rdata_o,
    output logic                  instr_err_o,
    instr_fetch_axi_master_if.master m_axi,
    output logic [CNT_WIDTH-1:0]  fetch_count_o,
    output logic [CNT_WIDTH-1:0]  err_count_o
);

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic                  arvalid_q, arvalid_d;
    logic                  rready_q, rready_d;
    logic                  rvalid_q, rvalid_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [CNT_WIDTH-1:0]  fetch_cnt_q, fetch_cnt_d;
    logic [CNT_WIDTH-1:0]  err_cnt_q, err_cnt_d;
    logic                  gnt;
    logic                  resp_err;

    // Low two address bits are discarded; masking keeps every input bit in use.
    logic [ADDR_WIDTH-1:0] aligned_addr;
    assign aligned_addr = instr_addr_i & ~(ADDR_WIDTH'(3));
    assign resp_err     = (m_axi.rresp != 2'b00);

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            araddr_q    <= '0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rvalid_q    <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            fetch_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            araddr_q    <= araddr_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            rvalid_q    <= rvalid_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            fetch_cnt_q <= fetch_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    // Next-state, next-register values and the combinational grant.
    always_comb begin
        state_d     = state_q;
        araddr_d    = araddr_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        rvalid_d    = 1'b0;
        err_d       = err_q;
        rdata_d     = rdata_q;
        fetch_cnt_d = fetch_cnt_q;
        err_cnt_d   = err_cnt_q;
        gnt         = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (instr_req_i) begin
                    araddr_d  = aligned_addr;
                    arvalid_d = 1'b1;
                    state_d   = ADDR;
                end
            end
            ADDR: begin
                // arvalid is always high here; the request line is not
                // consulted so a dropped request still completes.
                if (m_axi.arready) begin
                    gnt       = 1'b1;
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (m_axi.rvalid && rready_q) begin
                    rdata_d  = m_axi.rdata;
                    err_d    = resp_err;
                    rvalid_d = 1'b1;
                    rready_d = 1'b0;
                    if (fetch_cnt_q != '1) begin
                        fetch_cnt_d = fetch_cnt_q + 1'b1;
                    end
                    if (resp_err && (err_cnt_q != '1)) begin
                        err_cnt_d = err_cnt_q + 1'b1;
                    end
                    if (instr_req_i) begin
                        araddr_d  = aligned_addr;
                        arvalid_d = 1'b1;
                        state_d   = ADDR;
                    end else begin
                        state_d   = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign m_axi.araddr  = araddr_q;
    assign m_axi.arvalid = arvalid_q;
    assign m_axi.arprot  = 3'b100;
    assign m_axi.rready  = rready_q;

    assign instr_gnt_o    = gnt;
    assign instr_rvalid_o = rvalid_q;
    assign instr_rdata_o  = rdata_q;
    assign instr_err_o    = err_q;
    assign fetch_count_o  = fetch_cnt_q;
    assign err_count_o    = err_cnt_q;

endmodule

// File: tb/tb_instr_fetch_axi_master.sv
// Bench for instr_fetch_axi_master: directed fetch vectors, a scoreboard of
// expected instruction words and a monitor that checks each rvalid pulse.
module tb_instr_fetch_axi_master;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req;
    logic [AW-1:0] addr;
    logic          gnt;
    logic          rv;
    logic [DW-1:0] rdata;
    logic          err;
    logic [CW-1:0] fcnt;
    logic [CW-1:0] ecnt;

    always #5 clk = ~clk;

    instr_fetch_axi_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    instr_fetch_axi_master #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .CNT_WIDTH (CW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .instr_req_i   (req),
        .instr_addr_i  (addr),
        .instr_gnt_o   (gnt),
        .instr_rvalid_o(rv),
        .instr_rdata_o (rdata),
        .instr_err_o   (err),
        .m_axi         (bus),
        .fetch_count_o (fcnt),
        .err_count_o   (ecnt)
    );

    // ---------------- slave model ----------------
    logic          ar_block;
    logic          r_block;
    logic          s_rv;
    logic [DW-1:0] s_rdata;
    logic [1:0]    s_rresp;

    assign bus.arready = !ar_block;
    assign bus.rvalid  = s_rv & !r_block;
    assign bus.rdata   = s_rdata;
    assign bus.rresp   = s_rresp;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h80:  return 32'hF81F_F06F;
            32'h84:  return 32'h0000_0013;
            32'h88:  return 32'h0010_0093;
            32'h8C:  return 32'h0020_8113;
            32'h100: return 32'hDEAD_BEEF;
            32'h104: return 32'h0000_8067;
            default: return 32'h0BAD_0000 | {16'h0, a[15:0]};
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_rv    <= 1'b0;
            s_rdata <= '0;
            s_rresp <= 2'b00;
        end else begin
            if (bus.rvalid && bus.rready) s_rv <= 1'b0;
            if (bus.arvalid && bus.arready) begin
                s_rv    <= 1'b1;
                s_rdata <= mem_word(bus.araddr);
                s_rresp <= (bus.araddr == 32'h100) ? 2'b10 : 2'b00;
            end
        end
    end

    // ---------------- bookkeeping ----------------
    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int gnt_total = 0;
    logic [32:0] sb[$];
    int rv_cyc[$];
    int gnt_cyc[$];
    logic [31:0] v_addr[$];
    logic [31:0] v_data[$];
    logic        v_err[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on every instruction-valid pulse.
    always @(negedge clk) begin
        logic [32:0] e;
        if (gnt) gnt_total++;
        if (rst_n && rv) begin
            rv_cyc.push_back(cyc);
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_rvalid: got rdata=%h err=%0d expected no pulse", rdata, err);
            end else begin
                e = sb.pop_front();
                check("rdata", rdata, e[31:0]);
                check("err", 32'(err), 32'(e[32]));
            end
        end
    end

    task automatic add_vec(input logic [31:0] a, input logic [31:0] d, input logic e);
        v_addr.push_back(a);
        v_data.push_back(d);
        v_err.push_back(e);
    endtask

    // Core driver: present each address until granted, then move on at once.
    task automatic run_vectors();
        bit ok;
        gnt_cyc.delete();
        for (int i = 0; i < v_addr.size(); i++) begin
            req  = 1'b1;
            addr = v_addr[i];
            ok   = 1'b0;
            for (int k = 0; k < 40 && !ok; k++) begin
                @(negedge clk);
                if (gnt) begin
                    ok = 1'b1;
                    gnt_cyc.push_back(cyc);
                    check("araddr", bus.araddr, v_addr[i] & 32'hFFFF_FFFC);
                    check("arvalid_at_gnt", 32'(bus.arvalid), 32'd1);
                    sb.push_back({v_err[i], v_data[i]});
                end
            end
            check("gnt_seen", 32'(ok), 32'd1);
        end
        req  = 1'b0;
        addr = '0;
        v_addr.delete();
        v_data.delete();
        v_err.delete();
    endtask

    task automatic drain();
        for (int k = 0; k < 50 && sb.size() != 0; k++) @(negedge clk);
        #1;
        check("drain_left", 32'(sb.size()), 32'd0);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int start;
        int g0;
        int n0;
        req      = 1'b0;
        addr     = '0;
        ar_block = 1'b0;
        r_block  = 1'b0;
        rst_n    = 1'b0;

        // Reset state.
        #12;
        check("rst_gnt",     32'(gnt), 32'd0);
        check("rst_rvalid",  32'(rv), 32'd0);
        check("rst_err",     32'(err), 32'd0);
        check("rst_rdata",   rdata, 32'd0);
        check("rst_araddr",  bus.araddr, 32'd0);
        check("rst_arvalid", 32'(bus.arvalid), 32'd0);
        check("rst_rready",  32'(bus.rready), 32'd0);
        check("rst_fcnt",    32'(fcnt), 32'd0);
        check("rst_ecnt",    32'(ecnt), 32'd0);
        check("arprot",      32'(bus.arprot), 32'd4);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single fetch latency.
        rv_cyc.delete();
        start = cyc;
        add_vec(32'h80, 32'hF81F_F06F, 1'b0);
        run_vectors();
        drain();
        check("gnt_latency", 32'(gnt_cyc.size() > 0 ? gnt_cyc[0] - start : -1), 32'd1);
        check("rvalid_latency", 32'(rv_cyc.size() > 0 ? rv_cyc[0] - start : -1), 32'd3);
        check("fcnt_single", 32'(fcnt), 32'd1);
        check("ecnt_single", 32'(ecnt), 32'd0);

        // Back-to-back fetches.
        do_reset();
        rv_cyc.delete();
        add_vec(32'h80, 32'hF81F_F06F, 1'b0);
        add_vec(32'h84, 32'h0000_0013, 1'b0);
        add_vec(32'h88, 32'h0010_0093, 1'b0);
        add_vec(32'h8C, 32'h0020_8113, 1'b0);
        run_vectors();
        drain();
        check("b2b_pulses", 32'(rv_cyc.size()), 32'd4);
        for (int i = 1; i < 4; i++) begin
            check("b2b_rv_gap",  32'(rv_cyc.size() > i ? rv_cyc[i] - rv_cyc[i-1] : -1), 32'd2);
            check("b2b_gnt_gap", 32'(gnt_cyc.size() > i ? gnt_cyc[i] - gnt_cyc[i-1] : -1), 32'd2);
        end
        check("fcnt_b2b", 32'(fcnt), 32'd4);

        // AR stall: arready low for 5 cycles then high.
        do_reset();
        ar_block = 1'b1;
        g0   = gnt_total;
        req  = 1'b1;
        addr = 32'h8C;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_arvalid", 32'(bus.arvalid), 32'd1);
            check("stall_araddr",  bus.araddr, 32'h8C);
            check("stall_no_gnt",  32'(gnt), 32'd0);
        end
        @(posedge clk);
        #1 ar_block = 1'b0;
        @(negedge clk);
        check("stall_arvalid6", 32'(bus.arvalid), 32'd1);
        check("stall_araddr6",  bus.araddr, 32'h8C);
        check("stall_gnt",      32'(gnt), 32'd1);
        sb.push_back({1'b0, 32'h0020_8113});
        req  = 1'b0;
        addr = '0;
        drain();
        check("stall_gnt_count", 32'(gnt_total - g0), 32'd1);
        check("fcnt_stall", 32'(fcnt), 32'd1);

        // Error response, then a clean fetch.
        do_reset();
        add_vec(32'h100, 32'hDEAD_BEEF, 1'b1);
        run_vectors();
        drain();
        check("fcnt_err", 32'(fcnt), 32'd1);
        check("ecnt_err", 32'(ecnt), 32'd1);
        add_vec(32'h104, 32'h0000_8067, 1'b0);
        run_vectors();
        drain();
        check("fcnt_after_ok", 32'(fcnt), 32'd2);
        check("ecnt_after_ok", 32'(ecnt), 32'd1);

        // Misaligned address is rounded down.
        add_vec(32'h83, 32'hF81F_F06F, 1'b0);
        run_vectors();
        drain();
        check("fcnt_misalign", 32'(fcnt), 32'd3);

        // Reset while waiting in DATA.
        r_block = 1'b1;
        add_vec(32'h88, 32'h0010_0093, 1'b0);
        run_vectors();
        @(negedge clk);
        check("data_rready", 32'(bus.rready), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_arvalid", 32'(bus.arvalid), 32'd0);
        check("mid_rst_rready",  32'(bus.rready), 32'd0);
        check("mid_rst_fcnt",    32'(fcnt), 32'd0);
        check("mid_rst_ecnt",    32'(ecnt), 32'd0);
        sb.delete();
        r_block = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1 n0 = rv_cyc.size();
        for (int i = 0; i < 4; i++) @(negedge clk);
        #1 check("mid_rst_no_rvalid", 32'(rv_cyc.size() - n0), 32'd0);
        @(negedge clk);
        add_vec(32'h80, 32'hF81F_F06F, 1'b0);
        run_vectors();
        drain();
        check("fcnt_post_rst", 32'(fcnt), 32'd1);

        // Saturation with a 4-bit counter.
        do_reset();
        for (int i = 0; i < 17; i++) begin
            add_vec(32'h200 + 32'(4 * i), 32'h0BAD_0200 + 32'(4 * i), 1'b0);
        end
        run_vectors();
        drain();
        check("fcnt_sat", 32'(fcnt), 32'd15);
        check("ecnt_sat", 32'(ecnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
